// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multicycle control unit and the datapath/instruction register:
// instruction fields and ALU flag in, every datapath enable and mux select out.
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic                 RegWrite;
    logic [1:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 illegal;
    logic [3:0]           state_o;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal, state_o
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal, state_o
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RISC-V core with a split main/ALU decode.
// Optional macro BNE_EN: the branch state also resolves bne (taken on ~zero).
module multicycle_control_unit #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_control_unit_if.master cu
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    state_t     state;
    state_t     next_state;
    logic       op_bad;
    logic       pc_update;
    logic       branch;
    logic       taken;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        op_bad     = 1'b0;
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (cu.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYP:      next_state = EXECUTER;
                    OP_ITYP:      next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BR:        next_state = BEQ;
                    default: begin
                        op_bad     = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR:   next_state = (cu.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            JAL:      next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
`ifdef BNE_EN
        taken = (cu.funct3 == 3'b001) ? ~cu.zero : cu.zero;
`else
        taken = cu.zero;
`endif
    end

    always_comb begin
        case (cu.op)
            OP_SW:   imm_src = 2'b01;
            OP_BR:   imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // ALU decode: funct3 only matters for ALUOp=10; sub needs an R-type op with bit 30 set
    always_comb begin
        alu_ctrl = 3'b000;
        case (alu_op)
            2'b01:   alu_ctrl = 3'b001;
            2'b10: begin
                case (cu.funct3)
                    3'b000:  alu_ctrl = (cu.op[5] & cu.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    // Write enables are gated by rst so nothing commits while reset is held
    assign cu.PCWrite    = ~rst & (pc_update | (branch & taken));
    assign cu.IRWrite    = ~rst & ir_write;
    assign cu.MemWrite   = ~rst & mem_write;
    assign cu.RegWrite   = ~rst & reg_write;
    assign cu.illegal    = ~rst & op_bad;
    assign cu.AdrSrc     = adr_src;
    assign cu.ResultSrc  = result_src;
    assign cu.ALUSrcA    = alu_src_a;
    assign cu.ALUSrcB    = alu_src_b;
    assign cu.ImmSrc     = imm_src;
    assign cu.ALUControl = ALUCTRL_W'(alu_ctrl);
    assign cu.state_o    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class through
// its state sequence and compares control outputs against hand-derived values.
module tb_multicycle_control_unit;

    localparam int ALUCTRL_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUCTRL_W(ALUCTRL_W)) cu_if ();

    multicycle_control_unit #(.ALUCTRL_W(ALUCTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu_if.master)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        cu_if.op       = o;
        cu_if.funct3   = f3;
        cu_if.funct7b5 = f7;
    endtask

    initial begin
        set_instr(7'b0000011, 3'b010, 1'b1);
        cu_if.zero = 1'b0;

        // reset held for three edges
        repeat (3) tick();
        chk("rst_state", cu_if.state_o, 0);
        chk("rst_pcw", cu_if.PCWrite, 0);
        chk("rst_irw", cu_if.IRWrite, 0);
        chk("rst_memw", cu_if.MemWrite, 0);
        chk("rst_regw", cu_if.RegWrite, 0);
        chk("rst_ill", cu_if.illegal, 0);
        chk("rst_srcb", cu_if.ALUSrcB, 2);
        rst = 1'b0;
        #1;
        chk("rel_irw", cu_if.IRWrite, 1);
        chk("rel_pcw", cu_if.PCWrite, 1);
        chk("rel_state", cu_if.state_o, 0);
        chk("fetch_res", cu_if.ResultSrc, 2);

        // lw x6,-4(x9) = 0xFFC4A303
        tick(); chk("lw_s1", cu_if.state_o, 1);
        chk("lw_s1_srca", cu_if.ALUSrcA, 1);
        chk("lw_s1_regw", cu_if.RegWrite, 0);
        tick(); chk("lw_s2", cu_if.state_o, 2);
        chk("lw_s2_srcb", cu_if.ALUSrcB, 1);
        chk("lw_imm", cu_if.ImmSrc, 0);
        tick(); chk("lw_s3", cu_if.state_o, 3);
        chk("lw_s3_adr", cu_if.AdrSrc, 1);
        chk("lw_s3_regw", cu_if.RegWrite, 0);
        tick(); chk("lw_s4", cu_if.state_o, 4);
        chk("lw_s4_regw", cu_if.RegWrite, 1);
        chk("lw_s4_res", cu_if.ResultSrc, 1);
        tick(); chk("lw_end", cu_if.state_o, 0);
        chk("lw_end_regw", cu_if.RegWrite, 0);

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); chk("sw_s1", cu_if.state_o, 1);
        chk("sw_imm", cu_if.ImmSrc, 1);
        tick(); chk("sw_s2", cu_if.state_o, 2);
        tick(); chk("sw_s5", cu_if.state_o, 5);
        chk("sw_memw", cu_if.MemWrite, 1);
        chk("sw_regw", cu_if.RegWrite, 0);
        chk("sw_adr", cu_if.AdrSrc, 1);
        tick(); chk("sw_end", cu_if.state_o, 0);
        chk("sw_end_memw", cu_if.MemWrite, 0);

        // R-type sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick(); chk("sub_s1", cu_if.state_o, 1);
        chk("sub_dec_alu", cu_if.ALUControl, 0);
        tick(); chk("sub_s6", cu_if.state_o, 6);
        chk("sub_alu", cu_if.ALUControl, 1);
        chk("sub_srca", cu_if.ALUSrcA, 2);
        chk("sub_srcb", cu_if.ALUSrcB, 0);
        tick(); chk("sub_s7", cu_if.state_o, 7);
        chk("sub_regw", cu_if.RegWrite, 1);
        tick(); chk("sub_end", cu_if.state_o, 0);

        // R-type or
        set_instr(7'b0110011, 3'b110, 1'b0);
        tick(); tick();
        chk("or_s6", cu_if.state_o, 6);
        chk("or_alu", cu_if.ALUControl, 3);
        tick(); tick(); chk("or_end", cu_if.state_o, 0);

        // addi with bit 30 set must still add (op[5]=0)
        set_instr(7'b0010011, 3'b000, 1'b1);
        tick(); tick();
        chk("addi_s8", cu_if.state_o, 8);
        chk("addi_alu", cu_if.ALUControl, 0);
        chk("addi_srcb", cu_if.ALUSrcB, 1);
        cu_if.funct3 = 3'b010;
        #1; chk("slti_alu", cu_if.ALUControl, 5);
        cu_if.funct3 = 3'b111;
        #1; chk("andi_alu", cu_if.ALUControl, 2);
        tick(); chk("addi_s7", cu_if.state_o, 7);
        tick(); chk("addi_end", cu_if.state_o, 0);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        tick(); chk("jal_s1", cu_if.state_o, 1);
        tick(); chk("jal_s9", cu_if.state_o, 9);
        chk("jal_pcw", cu_if.PCWrite, 1);
        chk("jal_imm", cu_if.ImmSrc, 3);
        tick(); chk("jal_s7", cu_if.state_o, 7);
        chk("jal_regw", cu_if.RegWrite, 1);
        tick(); chk("jal_end", cu_if.state_o, 0);

        // beq taken / not taken
        set_instr(7'b1100011, 3'b000, 1'b0);
        cu_if.zero = 1'b1;
        tick(); chk("beq_s1", cu_if.state_o, 1);
        chk("beq_dec_pcw", cu_if.PCWrite, 0);
        tick(); chk("beq_s10", cu_if.state_o, 10);
        chk("beq_t_pcw", cu_if.PCWrite, 1);
        chk("beq_alu", cu_if.ALUControl, 1);
        chk("beq_imm", cu_if.ImmSrc, 2);
        cu_if.zero = 1'b0;
        #1; chk("beq_nt_pcw", cu_if.PCWrite, 0);
        tick(); chk("beq_end", cu_if.state_o, 0);

        // bne with zero=0
        set_instr(7'b1100011, 3'b001, 1'b0);
        cu_if.zero = 1'b0;
        tick(); tick();
        chk("bne_s10", cu_if.state_o, 10);
`ifdef BNE_EN
        chk("bne_pcw", cu_if.PCWrite, 1);
`else
        chk("bne_pcw", cu_if.PCWrite, 0);
`endif
        tick(); chk("bne_end", cu_if.state_o, 0);

        // illegal opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        chk("ill_fetch", cu_if.illegal, 0);
        tick(); chk("ill_s1", cu_if.state_o, 1);
        chk("ill_pulse", cu_if.illegal, 1);
        tick(); chk("ill_end", cu_if.state_o, 0);
        chk("ill_clr", cu_if.illegal, 0);

        // reset mid-lw aborts asynchronously
        set_instr(7'b0000011, 3'b010, 1'b0);
        tick(); tick(); tick();
        chk("ab_s3", cu_if.state_o, 3);
        rst = 1'b1;
        #1;
        chk("ab_state", cu_if.state_o, 0);
        chk("ab_regw", cu_if.RegWrite, 0);
        chk("ab_irw", cu_if.IRWrite, 0);
        tick(); chk("ab_hold", cu_if.state_o, 0);
        rst = 1'b0;
        tick(); chk("ab_restart", cu_if.state_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
